// File: rtl/vga_pkg.sv
// Shared VGA pixel-port widths, plot-arbiter state encoding and palette constants.
package vga_pkg;

  localparam int VGA_X_W      = 8;
  localparam int VGA_Y_W      = 7;
  localparam int VGA_COLOUR_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  localparam logic [VGA_COLOUR_W-1:0] COL_BLACK  = 3'b000;
  localparam logic [VGA_COLOUR_W-1:0] COL_BLUE   = 3'b001;
  localparam logic [VGA_COLOUR_W-1:0] COL_GREEN  = 3'b010;
  localparam logic [VGA_COLOUR_W-1:0] COL_CYAN   = 3'b011;
  localparam logic [VGA_COLOUR_W-1:0] COL_RED    = 3'b100;
  localparam logic [VGA_COLOUR_W-1:0] COL_YELLOW = 3'b110;
  localparam logic [VGA_COLOUR_W-1:0] COL_WHITE  = 3'b111;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin finder: first active request at or after rr_ptr_i, wrapping.
// Produces a one-hot grant, its index, and whether any request was found.
module rr_pick #(
  parameter int NUM_REQ = 6,
  parameter int IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rr_ptr_i is always below NUM_REQ, so one subtraction wraps the sum.
      cand = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found                     = 1'b1;
        grant_o[cand[IDX_W-1:0]]  = 1'b1;
        idx_o                     = cand[IDX_W-1:0];
      end
    end
  end

  assign any_o = found;

endmodule

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the single VGA pixel-write port; an owner keeps it until its last pixel.
// Define PLOT_ARB_WATCHDOG_EN to revoke a grant after STALL_MAX consecutive owner stall cycles.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ  = 6,
  parameter int X_W      = VGA_X_W,
  parameter int Y_W      = VGA_Y_W,
  parameter int COLOUR_W = VGA_COLOUR_W
`ifdef PLOT_ARB_WATCHDOG_EN
  , parameter int STALL_MAX = 255
`endif
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ-1:0]           req_last,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_plot,
  output logic                         busy,
  output logic [NUM_REQ-1:0]           stall_err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_e            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [X_W-1:0]        vga_x_q, vga_x_d;
  logic [Y_W-1:0]        vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0]   vga_colour_q, vga_colour_d;
  logic                  vga_plot_q, vga_plot_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IDX_W-1:0]      pick_idx;
  logic                  pick_any;
  logic                  own_req, own_last, release_c;
  logic [IDX_W-1:0]      owner_next;

`ifdef PLOT_ARB_WATCHDOG_EN
  localparam int CNT_W = $clog2(STALL_MAX + 1);
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic [NUM_REQ-1:0]    stall_err_q, stall_err_d;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign own_req    = req[owner_q];
  assign own_last   = req_last[owner_q];
  assign owner_next = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    rr_ptr_d     = rr_ptr_q;
    vga_x_d      = vga_x_q;
    vga_y_d      = vga_y_q;
    vga_colour_d = vga_colour_q;
    vga_plot_d   = 1'b0;
    release_c    = 1'b0;
`ifdef PLOT_ARB_WATCHDOG_EN
    stall_cnt_d  = stall_cnt_q;
    stall_err_d  = stall_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_grant;
          owner_d = pick_idx;
`ifdef PLOT_ARB_WATCHDOG_EN
          stall_cnt_d = '0;
`endif
        end
      end
      BURST: begin
        if (own_req) begin
          vga_x_d      = req_x[int'(owner_q)*X_W +: X_W];
          vga_y_d      = req_y[int'(owner_q)*Y_W +: Y_W];
          vga_colour_d = req_colour[int'(owner_q)*COLOUR_W +: COLOUR_W];
          vga_plot_d   = 1'b1;
          release_c    = own_last;
`ifdef PLOT_ARB_WATCHDOG_EN
          stall_cnt_d  = '0;
`endif
        end
`ifdef PLOT_ARB_WATCHDOG_EN
        else if (stall_cnt_q == CNT_W'(STALL_MAX - 1)) begin
          release_c            = 1'b1;
          stall_err_d[owner_q] = 1'b1;
          stall_cnt_d          = '0;
        end else begin
          stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // Releasing moves the pointer past the owner so the next IDLE cycle favours someone else.
    if (release_c) begin
      state_d  = IDLE;
      grant_d  = '0;
      rr_ptr_d = owner_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
    end
  end

`ifdef PLOT_ARB_WATCHDOG_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt_q <= '0;
      stall_err_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  assign stall_err = stall_err_q;
`else
  assign stall_err = '0;
`endif

  assign grant      = grant_q;
  assign busy       = (state_q == BURST);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Bench for vga_plot_arbiter: directed vector table, hand-written corner sequences, random traffic vs a model.
module tb_vga_plot_arbiter;

  localparam int NUM_REQ  = 6;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;
`ifdef PLOT_ARB_WATCHDOG_EN
  localparam int STALL_RUN = 3;
`else
  localparam int STALL_RUN = 4;
`endif

  logic                        clk = 1'b0;
  logic                        resetn;
  logic [NUM_REQ-1:0]          req, req_last, grant, stall_err;
  logic [NUM_REQ*X_W-1:0]      req_x;
  logic [NUM_REQ*Y_W-1:0]      req_y;
  logic [NUM_REQ*COLOUR_W-1:0] req_colour;
  logic [X_W-1:0]              vga_x;
  logic [Y_W-1:0]              vga_y;
  logic [COLOUR_W-1:0]         vga_colour;
  logic                        vga_plot, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_plot_arbiter #(
    .NUM_REQ(NUM_REQ), .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W)
`ifdef PLOT_ARB_WATCHDOG_EN
    , .STALL_MAX(4)
`endif
  ) dut (
    .clk(clk), .resetn(resetn), .req(req), .req_last(req_last),
    .req_x(req_x), .req_y(req_y), .req_colour(req_colour),
    .grant(grant), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot), .busy(busy), .stall_err(stall_err)
  );

  typedef struct {
    logic [NUM_REQ-1:0] rq;
    logic [NUM_REQ-1:0] lst;
    int                 own, x, y, c;
    logic [NUM_REQ-1:0] eg;
    logic               ep;
    int                 ex, ey, ec;
    logic               eb;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: plain integers derived from the arbitration rules.
  bit  m_busy;
  int  m_owner, m_ptr;
  logic [NUM_REQ-1:0] e_grant;
  logic e_plot, e_busy;
  int  e_x, e_y, e_c;
  int  rem[NUM_REQ];
  int  srun[NUM_REQ];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c);
    req_x[i*X_W +: X_W]                = X_W'(x);
    req_y[i*Y_W +: Y_W]                = Y_W'(y);
    req_colour[i*COLOUR_W +: COLOUR_W] = COLOUR_W'(c);
  endtask

  task automatic check_outs(input string tag, input logic [NUM_REQ-1:0] eg, input logic ep,
                            input logic eb, input int ex, input int ey, input int ec);
    chk($sformatf("%s.grant", tag), grant, eg);
    chk($sformatf("%s.busy", tag), busy, eb);
    chk($sformatf("%s.plot", tag), vga_plot, ep);
    if (ep) begin
      chk($sformatf("%s.x", tag), vga_x, ex);
      chk($sformatf("%s.y", tag), vga_y, ey);
      chk($sformatf("%s.colour", tag), vga_colour, ec);
    end
  endtask

  task automatic add(input logic [5:0] rq, input logic [5:0] lst, input int own, input int x,
                     input int y, input int c, input logic [5:0] eg, input logic ep,
                     input int ex, input int ey, input int ec, input logic eb);
    vec_t v;
    v.rq = rq; v.lst = lst; v.own = own; v.x = x; v.y = y; v.c = c;
    v.eg = eg; v.ep = ep; v.ex = ex; v.ey = ey; v.ec = ec; v.eb = eb;
    tbl.push_back(v);
  endtask

  // Advance the model across one clock edge using the inputs currently driven.
  task automatic step_model();
    bit picked;
    e_plot = 1'b0;
    if (!m_busy) begin
      picked = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (!picked && req[i]) begin
          picked  = 1'b1;
          m_busy  = 1'b1;
          m_owner = i;
        end
      end
    end else if (req[m_owner]) begin
      e_plot = 1'b1;
      e_x = int'(req_x[m_owner*X_W +: X_W]);
      e_y = int'(req_y[m_owner*Y_W +: Y_W]);
      e_c = int'(req_colour[m_owner*COLOUR_W +: COLOUR_W]);
      if (req_last[m_owner]) begin
        m_busy = 1'b0;
        m_ptr  = (m_owner + 1) % NUM_REQ;
      end
    end
    e_busy  = m_busy;
    e_grant = m_busy ? NUM_REQ'(1 << m_owner) : '0;
  endtask

  initial begin
    resetn = 1'b0; req = '0; req_last = '0; req_x = '0; req_y = '0; req_colour = '0;

    // Reset values
    #12;
    check_outs("reset", '0, 1'b0, 1'b0, 0, 0, 0);
    chk("reset.x", vga_x, 0);
    chk("reset.y", vga_y, 0);
    chk("reset.colour", vga_colour, 0);
    chk("reset.stall_err", stall_err, 0);
    @(posedge clk); #1; resetn = 1'b1;

    // Burst on 0 (x 10..12), then alternating 1/5 bursts of two pixels.
    add(6'h01, 6'h00, 0, 10, 5, 2, 6'h01, 0,  0, 0, 0, 1);
    add(6'h01, 6'h00, 0, 10, 5, 2, 6'h01, 1, 10, 5, 2, 1);
    add(6'h01, 6'h00, 0, 11, 5, 2, 6'h01, 1, 11, 5, 2, 1);
    add(6'h01, 6'h01, 0, 12, 5, 2, 6'h00, 1, 12, 5, 2, 0);
    add(6'h00, 6'h00, 0,  0, 0, 0, 6'h00, 0,  0, 0, 0, 0);
    add(6'h22, 6'h20, 1, 20, 7, 4, 6'h02, 0,  0, 0, 0, 1);
    add(6'h22, 6'h00, 1, 20, 7, 4, 6'h02, 1, 20, 7, 4, 1);
    add(6'h22, 6'h02, 1, 21, 7, 4, 6'h00, 1, 21, 7, 4, 0);
    add(6'h22, 6'h00, 5, 30, 9, 1, 6'h20, 0,  0, 0, 0, 1);
    add(6'h22, 6'h02, 5, 30, 9, 1, 6'h20, 1, 30, 9, 1, 1);
    add(6'h22, 6'h20, 5, 31, 9, 1, 6'h00, 1, 31, 9, 1, 0);
    add(6'h22, 6'h00, 1, 22, 7, 4, 6'h02, 0,  0, 0, 0, 1);
    add(6'h22, 6'h00, 1, 22, 7, 4, 6'h02, 1, 22, 7, 4, 1);
    add(6'h22, 6'h02, 1, 23, 7, 4, 6'h00, 1, 23, 7, 4, 0);
    add(6'h22, 6'h00, 5, 32, 9, 1, 6'h20, 0,  0, 0, 0, 1);
    add(6'h22, 6'h00, 5, 32, 9, 1, 6'h20, 1, 32, 9, 1, 1);
    add(6'h22, 6'h20, 5, 33, 9, 1, 6'h00, 1, 33, 9, 1, 0);
    add(6'h00, 6'h00, 0,  0, 0, 0, 6'h00, 0,  0, 0, 0, 0);

    foreach (tbl[n]) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == tbl[n].own) set_pix(i, tbl[n].x, tbl[n].y, tbl[n].c);
        else                 set_pix(i, 200 + i, 100 + i, tbl[n].c ^ 7);
      end
      req = tbl[n].rq; req_last = tbl[n].lst;
      cyc();
      check_outs($sformatf("tbl%0d", n), tbl[n].eg, tbl[n].ep, tbl[n].eb,
                 tbl[n].ex, tbl[n].ey, tbl[n].ec);
    end

    // Owner 2 stalls mid-burst; req_last without req must not end the burst.
    req = 6'b000100; req_last = '0; set_pix(2, 50, 20, 5);
    cyc(); check_outs("stall.grant", 6'b000100, 0, 1, 0, 0, 0);
    cyc(); check_outs("stall.pix0", 6'b000100, 1, 1, 50, 20, 5);
    req = '0; req_last = 6'b000100; set_pix(2, 99, 99, 0);
    for (int k = 0; k < STALL_RUN; k++) begin
      cyc(); check_outs($sformatf("stall.hold%0d", k), 6'b000100, 0, 1, 0, 0, 0);
    end
    req = 6'b000100; req_last = 6'b000100; set_pix(2, 51, 21, 6);
    cyc(); check_outs("stall.resume", '0, 1, 0, 51, 21, 6);
    req = '0; req_last = '0;
    cyc(); check_outs("stall.idle", '0, 0, 0, 0, 0, 0);

    // Single-pixel burst on requester 3
    req = 6'b001000; set_pix(3, 60, 30, 7);
    cyc(); check_outs("single.grant", 6'b001000, 0, 1, 0, 0, 0);
    req_last = 6'b001000;
    cyc(); check_outs("single.pix", '0, 1, 0, 60, 30, 7);
    req = '0; req_last = '0;
    cyc(); check_outs("single.after", '0, 0, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a burst
    req = 6'b000010; set_pix(1, 40, 10, 3);
    cyc(); check_outs("arst.grant", 6'b000010, 0, 1, 0, 0, 0);
    cyc(); check_outs("arst.pix", 6'b000010, 1, 1, 40, 10, 3);
    #2; resetn = 1'b0;
    #1;
    check_outs("arst.async", '0, 0, 0, 0, 0, 0);
    chk("arst.x", vga_x, 0);
    req = '0;
    @(posedge clk); #1; resetn = 1'b1;

    // Random traffic against the model
    m_busy = 1'b0; m_owner = 0; m_ptr = 0;
    for (int i = 0; i < NUM_REQ; i++) begin rem[i] = 0; srun[i] = 0; end
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        set_pix(i, $urandom_range(0, 255), $urandom_range(0, 127), $urandom_range(0, 7));
        req_last[i] = 1'($urandom_range(0, 1));
        if (m_busy && m_owner == i) begin
          if (srun[i] < 2 && $urandom_range(0, 3) == 0) begin
            req[i] = 1'b0;
            srun[i]++;
          end else begin
            req[i]      = 1'b1;
            srun[i]     = 0;
            req_last[i] = (rem[i] == 1);
            rem[i]--;
          end
        end else if (rem[i] > 0) begin
          req[i] = 1'b1;
        end else if ($urandom_range(0, 5) == 0) begin
          rem[i] = $urandom_range(1, 4);
          req[i] = 1'b1;
        end else begin
          req[i] = 1'b0;
        end
      end
      step_model();
      cyc();
      check_outs($sformatf("rand%0d", n), e_grant, e_plot, e_busy, e_x, e_y, e_c);
      chk($sformatf("rand%0d.stall_err", n), stall_err, 0);
    end

`ifdef PLOT_ARB_WATCHDOG_EN
    // Owner 4 stalls for the watchdog limit; requester 5 waits its turn.
    req = '0; req_last = '0; resetn = 1'b0;
    @(posedge clk); #1; resetn = 1'b1;
    req = 6'b110000;
    cyc(); check_outs("wd.grant", 6'b010000, 0, 1, 0, 0, 0);
    req = 6'b100000;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k < 3) check_outs($sformatf("wd.hold%0d", k), 6'b010000, 0, 1, 0, 0, 0);
      else       check_outs("wd.revoke", '0, 0, 0, 0, 0, 0);
    end
    chk("wd.err", stall_err, 6'b010000);
    cyc(); check_outs("wd.next", 6'b100000, 0, 1, 0, 0, 0);
    chk("wd.sticky", stall_err, 6'b010000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
